// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter.
//   DW_DEF / AW_DEF : default data and memory index widths
//   STARVE_W        : width of the B starvation counter
//   req_id_e        : requester identity, used to steer the winner mux
package mem_arb_pkg;
  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 10;
  localparam int STARVE_W = 4;

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } req_id_e;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// One requester port of the data memory arbiter.
//   req/we/addr/wdata : request, held by the requester until gnt
//   gnt               : combinational grant, transfer completes at this edge
//   rvalid/rdata      : registered read return, one cycle after a read grant
// master = requester side, slave = arbiter side.
interface data_mem_arbiter_if #(parameter int DW = 32);
  logic          req;
  logic          we;
  logic [31:0]   addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/data_mem_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles in which B asked and lost.
//   inc : B requested and was not granted this cycle
//   clr : B granted or not requesting (takes priority over inc)
//   cnt : current count, saturates at LIMIT
//   hit : cnt has reached LIMIT, B must win the next contested cycle
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter logic [STARVE_W-1:0] LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                clr,
  output logic [STARVE_W-1:0] cnt,
  output logic                hit
);
  assign hit = (cnt == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (inc && !hit)    cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of a single-ported data memory.
// A (CPU) has fixed priority; B (UART dump / debug) wins a contested cycle once
// it has been refused STARVE_LIMIT cycles in a row.
//   clk, rst          : clock, async active-low reset
//   a, b              : requester ports (slave modport)
//   mem_addr/we/wdata : to memory, driven by the winner (zero when idle)
//   mem_rdata         : combinational memory read data
//   addr_err          : pulses the cycle after a granted out-of-window access
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW           = DW_DEF,
  parameter int AW           = AW_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_arbiter_if.slave    a,
  data_mem_arbiter_if.slave    b,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_we,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 addr_err
);
  logic          hit, a_gnt, b_gnt, any_gnt;
  logic          a_in, b_in, w_in, w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata, rd_data;
  req_id_e       win;
  logic          a_rvalid_q, b_rvalid_q, err_q;
  logic [DW-1:0] a_rdata_q, b_rdata_q;

  // Grants are gated by rst so nothing is granted while reset is asserted.
  assign a_gnt   = rst & a.req & ~(b.req & hit);
  assign b_gnt   = rst & b.req & (~a.req | hit);
  assign any_gnt = a_gnt | b_gnt;
  assign a.gnt   = a_gnt;
  assign b.gnt   = b_gnt;

  assign a_in = (a.addr[31:AW] == '0);
  assign b_in = (b.addr[31:AW] == '0);

  always_comb begin
    win     = b_gnt ? ID_B : ID_A;
    w_addr  = (win == ID_B) ? b.addr[AW-1:0] : a.addr[AW-1:0];
    w_we    = (win == ID_B) ? b.we           : a.we;
    w_wdata = (win == ID_B) ? b.wdata        : a.wdata;
    w_in    = (win == ID_B) ? b_in           : a_in;
  end

  assign mem_addr  = any_gnt ? w_addr  : '0;
  assign mem_wdata = any_gnt ? w_wdata : '0;
  assign mem_we    = any_gnt & w_we & w_in;
  // Out-of-window reads still complete, but return zero rather than aliased data.
  assign rd_data   = w_in ? mem_rdata : '0;

  arb_starve_ctr #(.LIMIT(STARVE_LIMIT[STARVE_W-1:0])) u_ctr (
    .clk (clk),
    .rst (rst),
    .inc (b.req & ~b_gnt),
    .clr (b_gnt | ~b.req),
    .cnt (),
    .hit (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      a_rvalid_q <= a_gnt & ~a.we;
      b_rvalid_q <= b_gnt & ~b.we;
      if (a_gnt && !a.we) a_rdata_q <= rd_data;
      if (b_gnt && !b.we) b_rdata_q <= rd_data;
      err_q      <= any_gnt & ~w_in;
    end
  end

  assign a.rvalid = a_rvalid_q;
  assign a.rdata  = a_rdata_q;
  assign b.rvalid = b_rvalid_q;
  assign b.rdata  = b_rdata_q;
  assign addr_err = err_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LIMIT = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          addr_err;

  data_mem_arbiter_if #(.DW(DW)) a_if ();
  data_mem_arbiter_if #(.DW(DW)) b_if ();

  data_mem_arbiter #(.DW(DW), .AW(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .a(a_if.slave), .b(b_if.slave),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Power-up contents of a location, shared by the memory and the model.
  function automatic logic [31:0] init_val(input logic [31:0] ad);
    return (ad * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Memory: sync write, combinational read.
  logic [DW-1:0] env_mem [DEPTH];
  bit            env_wr  [DEPTH];
  always @(posedge clk) if (mem_we) begin
    env_mem[mem_addr] <= mem_wdata;
    env_wr[mem_addr]  <= 1'b1;
  end
  assign mem_rdata = env_wr[mem_addr] ? env_mem[mem_addr] : init_val({22'b0, mem_addr});

  // Reference model state
  logic [31:0] ref_mem [int];
  int          streak;
  logic        exp_arv, exp_brv, exp_err;
  logic [31:0] exp_ard, exp_brd;
  logic        last_ga, last_gb;
  int          n_tests = 0, n_fail = 0;

  function automatic logic [31:0] ref_rd(input logic [31:0] ad);
    return ref_mem.exists(int'(ad)) ? ref_mem[int'(ad)] : init_val(ad);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drv_a(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] wd);
    a_if.req = r; a_if.we = w; a_if.addr = ad; a_if.wdata = wd;
  endtask

  task automatic drv_b(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] wd);
    b_if.req = r; b_if.we = w; b_if.addr = ad; b_if.wdata = wd;
  endtask

  task automatic chk_regs();
    chk("a_rvalid", {31'b0, a_if.rvalid}, {31'b0, exp_arv});
    chk("a_rdata",  a_if.rdata, exp_ard);
    chk("b_rvalid", {31'b0, b_if.rvalid}, {31'b0, exp_brv});
    chk("b_rdata",  b_if.rdata, exp_brd);
    chk("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
  endtask

  // One clock cycle with the currently driven inputs, checked against the model.
  task automatic step();
    logic        ga, gb, g, we, inr, breq;
    logic [31:0] ad, wd;
    #1;
    breq = b_if.req;
    ga = a_if.req && !(b_if.req && streak == LIMIT);
    gb = b_if.req && (!a_if.req || streak == LIMIT);
    g  = ga || gb;
    ad = gb ? b_if.addr  : a_if.addr;
    we = gb ? b_if.we    : a_if.we;
    wd = gb ? b_if.wdata : a_if.wdata;
    inr = (ad < DEPTH);
    chk("a_gnt",  {31'b0, a_if.gnt}, {31'b0, ga});
    chk("b_gnt",  {31'b0, b_if.gnt}, {31'b0, gb});
    chk("starve", {28'b0, dut.u_ctr.cnt}, streak);
    chk("mem_we", {31'b0, mem_we}, {31'b0, g && we && inr});
    chk("mem_addr", {22'b0, mem_addr}, g ? ad % DEPTH : 0);
    if (g && we && inr) chk("mem_wdata", mem_wdata, wd);
    last_ga = ga; last_gb = gb;
    @(posedge clk);
    exp_arv = ga && !we;
    exp_brv = gb && !we;
    if (ga && !we) exp_ard = inr ? ref_rd(ad) : 32'h0;
    if (gb && !we) exp_brd = inr ? ref_rd(ad) : 32'h0;
    exp_err = g && !inr;
    if (g && we && inr) ref_mem[int'(ad)] = wd;
    streak = (breq && !gb) ? ((streak + 1 > LIMIT) ? LIMIT : streak + 1) : 0;
    #1;
    chk_regs();
  endtask

  function automatic logic [31:0] rnd_addr();
    return ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 15));
  endfunction

  initial begin
    int nb, nbv;
    streak = 0; exp_arv = 0; exp_brv = 0; exp_err = 0; exp_ard = 0; exp_brd = 0;
    last_ga = 0; last_gb = 0;
    drv_a(1, 0, 32'd1, 0);
    drv_b(1, 0, 32'd2, 0);
    #2;
    // reset state, with both ports requesting
    chk("rst_a_gnt", {31'b0, a_if.gnt}, 0);
    chk("rst_b_gnt", {31'b0, b_if.gnt}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk_regs();
    chk("rst_starve", {28'b0, dut.u_ctr.cnt}, 0);
    drv_a(0, 0, 0, 0); drv_b(0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // 1: A write then read addr 5
    drv_a(1, 1, 32'd5, 32'hDEADBEEF); step();
    drv_a(1, 0, 32'd5, 0);            step();
    chk("t1_rdata", a_if.rdata, 32'hDEADBEEF);
    chk("t1_rvalid", {31'b0, a_if.rvalid}, 1);
    chk("t1_b_idle", {31'b0, b_if.rvalid}, 0);
    drv_a(0, 0, 0, 0); step();

    // 2: both held, expect A,A,A,A,B repeating
    drv_a(1, 0, 32'd1, 0); drv_b(1, 0, 32'd2, 0);
    nb = 0; nbv = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_gb) nb++;
      if (b_if.rvalid) nbv++;
      chk("t2_pattern", {31'b0, last_gb}, {31'b0, (i % 5) == 4});
    end
    chk("t2_b_grants", nb, 2);
    chk("t2_b_rvalid", nbv, 2);

    // 3: out-of-range accesses
    drv_a(0, 0, 0, 0); drv_b(1, 0, 32'h400, 0); step();
    chk("t3_b_rvalid", {31'b0, b_if.rvalid}, 1);
    chk("t3_b_rdata", b_if.rdata, 0);
    chk("t3_err_rd", {31'b0, addr_err}, 1);
    drv_b(0, 0, 0, 0); drv_a(1, 1, 32'h7FF_FFFF, 32'h1234); step();
    chk("t3_err_wr", {31'b0, addr_err}, 1);

    // 5: A writes 7, B reads 7 the next cycle
    drv_a(1, 1, 32'd7, 32'h11); step();
    drv_a(0, 0, 0, 0); drv_b(1, 0, 32'd7, 0); step();
    chk("t5_b_rdata", b_if.rdata, 32'h11);

    // 6: B refused 3 times, then A drops
    drv_a(1, 0, 32'd4, 0); drv_b(1, 0, 32'd8, 0);
    for (int i = 0; i < 3; i++) step();
    chk("t6_starve3", {28'b0, dut.u_ctr.cnt}, 3);
    drv_a(0, 0, 0, 0); step();
    chk("t6_b_won", {31'b0, last_gb}, 1);
    chk("t6_starve0", {28'b0, dut.u_ctr.cnt}, 0);
    drv_b(0, 0, 0, 0); step();

    // 4: reset asserted mid-cycle while A read is granted
    drv_a(1, 0, 32'd3, 0);
    #1 chk("t4_gnt_pre", {31'b0, a_if.gnt}, 1);
    rst = 1'b0;
    #1 chk("t4_gnt_rst", {31'b0, a_if.gnt}, 0);
    chk("t4_mem_we", {31'b0, mem_we}, 0);
    @(posedge clk); #1;
    exp_arv = 0; exp_brv = 0; exp_ard = 0; exp_brd = 0; exp_err = 0; streak = 0;
    chk_regs();
    drv_a(0, 0, 0, 0);
    rst = 1'b1;
    chk("t4_starve", {28'b0, dut.u_ctr.cnt}, 0);
    step();

    // random traffic; requesters hold until granted
    for (int i = 0; i < 400; i++) begin
      if (!a_if.req || last_ga)
        drv_a($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, rnd_addr(), $urandom);
      if (!b_if.req || last_gb)
        drv_b($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, rnd_addr(), $urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
